// File: rtl/rs_dispatch_ctrl_pkg.sv
// Types and defaults for the RS dispatch sequencer (rs_dispatch_ctrl).
package rs_dispatch_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } DISP_STATE_T;

    localparam int DISPATCH_QUEUE_DEPTH    = 8;
    localparam int DISPATCH_RECOVER_CYCLES = 2;

    function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/sys_defs.sv
// Machine-wide definitions shared across the pipeline: RS row format, structure
// sizes and a small population-count lookup table.
package sys_defs;
    localparam int ROB_SIZE     = 32;
    localparam int NUM_PHYS_REG = 64;

    typedef struct packed {
        logic       valid;
        logic [7:0] opcode;
        logic [5:0] dest_tag;
        logic [5:0] src1_tag;
        logic [5:0] src2_tag;
        logic [4:0] rob_idx;
    } RS_ROW_T;

    localparam RS_ROW_T EMPTY_ROW = '0;

    // Number of set bits for any 4-bit value.
    localparam logic [2:0] BIT_COUNT_LUT [16] = '{
        3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
        3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4
    };
endpackage

// File: rtl/dispatch_fifo_mw.sv
// Multi-write/multi-read circular staging buffer: up to SS_SIZE compacted pushes
// and SS_SIZE in-order pops per cycle, with an occupancy count.
module dispatch_fifo_mw
    import sys_defs::*;
#(
    parameter int SS_SIZE = 2,
    parameter int DEPTH   = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push_en,
    input  logic [SS_SIZE-1:0]             push_valid,
    input  RS_ROW_T [SS_SIZE-1:0]          push_data,
    input  logic [$clog2(SS_SIZE):0]       pop_n,
    output RS_ROW_T [SS_SIZE-1:0]          peek_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic [$clog2(SS_SIZE):0]       push_n
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int N_W   = $clog2(SS_SIZE) + 1;

    RS_ROW_T            mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   wr_addr [SS_SIZE];
    logic [SS_SIZE-1:0] wr_en;
    logic [SS_SIZE-1:0] below;

    // A lane's slot is tail plus the number of valid lanes beneath it.
    always_comb begin
        wr_en = '0;
        below = '0;
        for (int i = 0; i < SS_SIZE; i++) begin
            below      = push_valid & SS_SIZE'((1 << i) - 1);
            wr_addr[i] = tail + PTR_W'(BIT_COUNT_LUT[4'(below)]);
            wr_en[i]   = push_en & push_valid[i];
        end
        push_n = push_en ? N_W'(BIT_COUNT_LUT[4'(push_valid)]) : '0;
    end

    always_comb begin
        for (int i = 0; i < SS_SIZE; i++) begin
            peek_data[i] = mem[head + PTR_W'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < SS_SIZE; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr[i]] <= push_data[i];
            end
        end
    end
endmodule

// File: rtl/rs_dispatch_ctrl.sv
// In-order dispatch sequencer between decode and the reservation station.
// Optional stall counters are built when DISPATCH_STATS_EN is defined.
module rs_dispatch_ctrl
    import sys_defs::*;
    import rs_dispatch_ctrl_pkg::*;
#(
    parameter int SS_SIZE        = 2,
    parameter int QUEUE_DEPTH    = DISPATCH_QUEUE_DEPTH,
    parameter int RS_SIZE        = 16,
    parameter int RECOVER_CYCLES = DISPATCH_RECOVER_CYCLES
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              branch_not_taken,
    input  logic [SS_SIZE-1:0]                dec_valid,
    input  RS_ROW_T [SS_SIZE-1:0]             dec_inst,
    output logic                              dec_ready,
    input  logic [$clog2(RS_SIZE):0]          rs_free_rows_next,
    input  logic [$clog2(ROB_SIZE):0]         rob_free_slots,
    input  logic [$clog2(NUM_PHYS_REG):0]     fl_free_regs,
    output logic [SS_SIZE-1:0]                dispatch_valid,
    output RS_ROW_T [SS_SIZE-1:0]             inst_out,
    output logic                              rs_enable,
    output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
    output logic [1:0]                        state_dbg
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                       stall_rs_cycles,
    output logic [31:0]                       stall_rob_cycles,
    output logic [31:0]                       stall_fl_cycles
`endif
);
    localparam int N_W   = $clog2(SS_SIZE) + 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int CR_W  = $clog2(RS_SIZE) + 1;
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    DISP_STATE_T           state;
    DISP_STATE_T           state_next;
    logic [RC_W-1:0]       rec_cnt;
    logic [RC_W-1:0]       rec_cnt_next;
    logic [CR_W-1:0]       rs_credit;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic [N_W-1:0]        n_raw;
    logic [N_W-1:0]        n;
    logic [N_W-1:0]        push_n;
    logic                  push_en;
    logic [31:0]           lim;
    RS_ROW_T [SS_SIZE-1:0] peek;

    dispatch_fifo_mw #(.SS_SIZE(SS_SIZE), .DEPTH(QUEUE_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (branch_not_taken),
        .push_en    (push_en),
        .push_valid (dec_valid),
        .push_data  (dec_inst),
        .pop_n      (n),
        .peek_data  (peek),
        .count      (count),
        .push_n     (push_n)
    );

    // Dispatch width is the tightest of queue, credit, ROB, free list and lanes.
    always_comb begin
        lim   = min_u(32'(count), 32'(rs_credit));
        lim   = min_u(lim, 32'(rob_free_slots));
        lim   = min_u(lim, 32'(fl_free_regs));
        lim   = min_u(lim, 32'(SS_SIZE));
        n_raw = N_W'(lim);
        n     = (state == RECOVER || branch_not_taken) ? '0 : n_raw;
    end

    // Ready depends on registered occupancy only, never on this cycle's dequeue.
    assign dec_ready   = (32'(QUEUE_DEPTH) - 32'(count) >= 32'(SS_SIZE)) && (state != RECOVER);
    assign push_en     = dec_ready && !branch_not_taken;
    assign count_next  = count + CNT_W'(push_n) - CNT_W'(n);
    assign rs_enable   = (state != RECOVER);
    assign queue_count = count;
    assign state_dbg   = state;

    always_comb begin
        dispatch_valid = '0;
        for (int i = 0; i < SS_SIZE; i++) begin
            inst_out[i] = EMPTY_ROW;
            if (N_W'(i) < n) begin
                dispatch_valid[i] = 1'b1;
                inst_out[i]       = peek[i];
            end
        end
    end

    always_comb begin
        state_next   = state;
        rec_cnt_next = rec_cnt;
        if (branch_not_taken) begin
            state_next   = RECOVER;
            rec_cnt_next = RC_W'(RECOVER_CYCLES - 1);
        end else begin
            case (state)
                IDLE:    if (push_n != '0) state_next = RUN;
                RUN:     if (count_next == '0) state_next = IDLE;
                RECOVER: begin
                    if (rec_cnt == '0) state_next = IDLE;
                    else rec_cnt_next = rec_cnt - 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Credit trails the RS by one cycle; during recovery the RS is known empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rec_cnt   <= '0;
            rs_credit <= CR_W'(RS_SIZE);
        end else begin
            state     <= state_next;
            rec_cnt   <= rec_cnt_next;
            rs_credit <= (state == RECOVER) ? CR_W'(RS_SIZE) : rs_free_rows_next;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic stall;
    logic bind_rs;
    logic bind_rob;

    // A stall cycle is charged to the binding resource; ties go rs, rob, fl.
    always_comb begin
        stall    = (count != '0) && (32'(n_raw) < min_u(32'(count), 32'(SS_SIZE)));
        bind_rs  = (32'(rs_credit) == 32'(n_raw));
        bind_rob = (32'(rob_free_slots) == 32'(n_raw));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_rs_cycles  <= '0;
            stall_rob_cycles <= '0;
            stall_fl_cycles  <= '0;
        end else if (stall) begin
            if (bind_rs) begin
                if (stall_rs_cycles != '1) stall_rs_cycles <= stall_rs_cycles + 1'b1;
            end else if (bind_rob) begin
                if (stall_rob_cycles != '1) stall_rob_cycles <= stall_rob_cycles + 1'b1;
            end else begin
                if (stall_fl_cycles != '1) stall_fl_cycles <= stall_fl_cycles + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Self-checking bench for rs_dispatch_ctrl: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_rs_dispatch_ctrl;
    import sys_defs::*;
    import rs_dispatch_ctrl_pkg::*;

    localparam int SS    = 2;
    localparam int QD    = 8;
    localparam int RSZ   = 16;
    localparam int RC    = 2;
    localparam int CR_W  = $clog2(RSZ) + 1;
    localparam int ROB_W = $clog2(ROB_SIZE) + 1;
    localparam int FL_W  = $clog2(NUM_PHYS_REG) + 1;
    localparam int QC_W  = $clog2(QD) + 1;
    localparam int ROW_W = $bits(RS_ROW_T);

    logic              clock = 1'b0;
    logic              reset;
    logic              branch_not_taken;
    logic [SS-1:0]     dec_valid;
    RS_ROW_T [SS-1:0]  dec_inst;
    logic              dec_ready;
    logic [CR_W-1:0]   rs_free_rows_next;
    logic [ROB_W-1:0]  rob_free_slots;
    logic [FL_W-1:0]   fl_free_regs;
    logic [SS-1:0]     dispatch_valid;
    RS_ROW_T [SS-1:0]  inst_out;
    logic              rs_enable;
    logic [QC_W-1:0]   queue_count;
    logic [1:0]        state_dbg;
`ifdef DISPATCH_STATS_EN
    logic [31:0]       stall_rs_cycles;
    logic [31:0]       stall_rob_cycles;
    logic [31:0]       stall_fl_cycles;
`endif

    int checks = 0;
    int passed = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

    rs_dispatch_ctrl #(
        .SS_SIZE(SS), .QUEUE_DEPTH(QD), .RS_SIZE(RSZ), .RECOVER_CYCLES(RC)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .branch_not_taken  (branch_not_taken),
        .dec_valid         (dec_valid),
        .dec_inst          (dec_inst),
        .dec_ready         (dec_ready),
        .rs_free_rows_next (rs_free_rows_next),
        .rob_free_slots    (rob_free_slots),
        .fl_free_regs      (fl_free_regs),
        .dispatch_valid    (dispatch_valid),
        .inst_out          (inst_out),
        .rs_enable         (rs_enable),
        .queue_count       (queue_count),
        .state_dbg         (state_dbg)
`ifdef DISPATCH_STATS_EN
        ,
        .stall_rs_cycles   (stall_rs_cycles),
        .stall_rob_cycles  (stall_rob_cycles),
        .stall_fl_cycles   (stall_fl_cycles)
`endif
    );

    // ---------------- reference model ----------------
    logic [ROW_W-1:0] exp_q[$];
    int               rec_left;
    int               cred;
    int               exp_size;
    int               exp_raw;
    int               exp_n;
    logic             exp_ready;
    logic             exp_rs_en;
    logic [SS-1:0]    exp_valid;
    RS_ROW_T [SS-1:0] exp_inst;
    logic [1:0]       exp_state;
    int               st_rs;
    int               st_rob;
    int               st_fl;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic RS_ROW_T rand_row();
        RS_ROW_T r;
        r = RS_ROW_T'($urandom);
        r.valid = 1'b1;
        return r;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        rec_left = 0;
        cred     = RSZ;
        st_rs    = 0;
        st_rob   = 0;
        st_fl    = 0;
    endfunction

    function automatic void model_predict();
        exp_size  = exp_q.size();
        exp_raw   = min2(min2(exp_size, cred), min2(int'(rob_free_slots), int'(fl_free_regs)));
        exp_raw   = min2(exp_raw, SS);
        exp_rs_en = (rec_left == 0);
        exp_ready = ((QD - exp_size) >= SS) && (rec_left == 0);
        exp_n     = (rec_left > 0 || branch_not_taken) ? 0 : exp_raw;
        exp_valid = '0;
        for (int i = 0; i < SS; i++) begin
            exp_inst[i] = EMPTY_ROW;
            if (i < exp_n) begin
                exp_valid[i] = 1'b1;
                exp_inst[i]  = RS_ROW_T'(exp_q[i]);
            end
        end
        if (rec_left > 0) exp_state = RECOVER;
        else if (exp_size == 0) exp_state = IDLE;
        else exp_state = RUN;
    endfunction

    function automatic void model_commit();
        if (exp_size > 0 && exp_raw < min2(exp_size, SS)) begin
            if (cred == exp_raw) st_rs++;
            else if (int'(rob_free_slots) == exp_raw) st_rob++;
            else st_fl++;
        end
        cred = exp_rs_en ? int'(rs_free_rows_next) : RSZ;
        if (branch_not_taken) begin
            exp_q.delete();
            rec_left = RC;
        end else if (rec_left > 0) begin
            rec_left--;
        end else begin
            for (int i = 0; i < exp_n; i++) void'(exp_q.pop_front());
            if (exp_ready) begin
                for (int i = 0; i < SS; i++) begin
                    if (dec_valid[i]) exp_q.push_back(dec_inst[i]);
                end
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [SS-1:0] v, input int rsn, input int rob, input int fl,
                         input logic flush);
        @(negedge clock);
        dec_valid = v;
        for (int i = 0; i < SS; i++) dec_inst[i] = rand_row();
        rs_free_rows_next = CR_W'(rsn);
        rob_free_slots    = ROB_W'(rob);
        fl_free_regs      = FL_W'(fl);
        branch_not_taken  = flush;
        #1;
        model_predict();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            drive('0, RSZ, 8, 8, 1'b0);
            model_commit();
            guard++;
        end
        drive('0, RSZ, 8, 8, 1'b0);
        checks++;
        if (queue_count !== '0) $display("FAIL drain_empty: queue_count=%0d want 0", queue_count);
        else passed++;
        model_commit();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        branch_not_taken = 1'b0;
        dec_valid = '0;
        for (int i = 0; i < SS; i++) dec_inst[i] = rand_row();
        rs_free_rows_next = CR_W'(RSZ);
        rob_free_slots = ROB_W'(8);
        fl_free_regs = FL_W'(8);
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (queue_count !== '0) $display("FAIL reset_count: got %0d want 0", queue_count);
        else passed++;
        checks++;
        if (dispatch_valid !== '0) $display("FAIL reset_dispatch: got %b want 00", dispatch_valid);
        else passed++;
        checks++;
        if (inst_out !== {SS{EMPTY_ROW}}) $display("FAIL reset_inst: got %h want empty", inst_out);
        else passed++;
        checks++;
        if (dec_ready !== 1'b1 || rs_enable !== 1'b1)
            $display("FAIL reset_ready_en: got ready=%b en=%b want 1 1", dec_ready, rs_enable);
        else passed++;
        checks++;
        if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        else passed++;
        reset = 1'b0;
        model_reset();
        #1;
        model_predict();
        model_commit();
    endtask

    task automatic test_basic_dispatch();
        RS_ROW_T a0, a1;
        drive(2'b11, RSZ, 8, 8, 1'b0);
        a0 = dec_inst[0];
        a1 = dec_inst[1];
        checks++;
        if (state_dbg !== IDLE || dispatch_valid !== 2'b00)
            $display("FAIL basic_pre: state=%0d valid=%b want 0 00", state_dbg, dispatch_valid);
        else passed++;
        model_commit();
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (state_dbg !== RUN) $display("FAIL basic_run: state=%0d want %0d", state_dbg, RUN);
        else passed++;
        checks++;
        if (dispatch_valid !== 2'b11) $display("FAIL basic_valid: got %b want 11", dispatch_valid);
        else passed++;
        checks++;
        if (inst_out[0] !== a0 || inst_out[1] !== a1)
            $display("FAIL basic_order: got %h %h want %h %h", inst_out[0], inst_out[1], a0, a1);
        else passed++;
        model_commit();
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (queue_count !== '0 || state_dbg !== IDLE)
            $display("FAIL basic_empty: count=%0d state=%0d want 0 0", queue_count, state_dbg);
        else passed++;
        model_commit();
    endtask

    task automatic test_credit_limit();
        drive(2'b11, RSZ, 0, 8, 1'b0);
        model_commit();
        drive(2'b11, 1, 0, 8, 1'b0);
        model_commit();
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (dispatch_valid !== 2'b01) $display("FAIL credit_valid: got %b want 01", dispatch_valid);
        else passed++;
        checks++;
        if (inst_out[0] !== exp_inst[0] || inst_out[1] !== EMPTY_ROW)
            $display("FAIL credit_row: got %h %h want %h %h", inst_out[0], inst_out[1], exp_inst[0], EMPTY_ROW);
        else passed++;
        model_commit();
        drive(2'b00, 0, 0, 0, 1'b0);
        checks++;
        if (queue_count !== QC_W'(3) || dispatch_valid !== 2'b00)
            $display("FAIL credit_hold: count=%0d valid=%b want 3 00", queue_count, dispatch_valid);
        else passed++;
        model_commit();
        drain();
    endtask

    task automatic test_fill_and_wrap();
        logic [ROW_W-1:0] seq[$];
        logic want_ready;
        int guard;
        for (int b = 0; b < 5; b++) begin
            drive(2'b11, 0, 0, 0, 1'b0);
            want_ready = (b < 4);
            checks++;
            if (dec_ready !== want_ready)
                $display("FAIL fill_ready_%0d: got %b want %b", b, dec_ready, want_ready);
            else passed++;
            if (b < 4) begin
                seq.push_back(dec_inst[0]);
                seq.push_back(dec_inst[1]);
            end
            model_commit();
        end
        guard = 0;
        while (seq.size() > 0 && guard < 12) begin
            drive(2'b00, RSZ, 8, 8, 1'b0);
            if (guard == 0) begin
                checks++;
                if (queue_count !== QC_W'(QD)) $display("FAIL fill_full: count=%0d want %0d", queue_count, QD);
                else passed++;
            end
            for (int i = 0; i < SS; i++) begin
                if (dispatch_valid[i] === 1'b1 && seq.size() > 0) begin
                    checks++;
                    if (inst_out[i] !== RS_ROW_T'(seq[0]))
                        $display("FAIL wrap_order lane %0d: got %h want %h", i, inst_out[i], seq[0]);
                    else passed++;
                    void'(seq.pop_front());
                end
            end
            model_commit();
            guard++;
        end
        checks++;
        if (seq.size() != 0) $display("FAIL wrap_drained: %0d rows never dispatched, want 0", seq.size());
        else passed++;
        drain();
    endtask

    task automatic test_sparse_lane();
        RS_ROW_T b;
        drive(2'b10, RSZ, 8, 8, 1'b0);
        b = dec_inst[1];
        model_commit();
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (dispatch_valid !== 2'b01 || inst_out[0] !== b || inst_out[1] !== EMPTY_ROW)
            $display("FAIL sparse_lane: valid=%b row0=%h row1=%h want 01 %h %h",
                     dispatch_valid, inst_out[0], inst_out[1], b, EMPTY_ROW);
        else passed++;
        model_commit();
        drain();
    endtask

    task automatic test_flush();
        drive(2'b11, 0, 0, 0, 1'b0);
        model_commit();
        drive(2'b11, 0, 0, 0, 1'b0);
        model_commit();
        drive(2'b01, RSZ, 0, 0, 1'b0);
        model_commit();
        drive(2'b11, 0, 8, 8, 1'b1);
        checks++;
        if (queue_count !== QC_W'(5) || dispatch_valid !== 2'b00)
            $display("FAIL flush_cycle: count=%0d valid=%b want 5 00", queue_count, dispatch_valid);
        else passed++;
        model_commit();
        for (int c = 0; c < RC; c++) begin
            drive(2'b11, 0, 8, 8, 1'b0);
            checks++;
            if (rs_enable !== 1'b0 || dec_ready !== 1'b0 || queue_count !== '0 || dispatch_valid !== '0)
                $display("FAIL flush_recover_%0d: en=%b ready=%b count=%0d valid=%b want 0 0 0 00",
                         c, rs_enable, dec_ready, queue_count, dispatch_valid);
            else passed++;
            model_commit();
        end
        drive(2'b11, 0, 8, 8, 1'b0);
        checks++;
        if (state_dbg !== IDLE || rs_enable !== 1'b1 || dec_ready !== 1'b1)
            $display("FAIL flush_exit: state=%0d en=%b ready=%b want 0 1 1", state_dbg, rs_enable, dec_ready);
        else passed++;
        model_commit();
        drain();
    endtask

    task automatic test_random();
        logic [SS-1:0] v;
        int rsn, rob, fl;
        logic flush;
        for (int c = 0; c < 300; c++) begin
            v     = SS'($urandom_range(0, 3));
            rsn   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, RSZ);
            rob   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 8);
            fl    = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 10);
            flush = ($urandom_range(0, 29) == 0);
            drive(v, rsn, rob, fl, flush);
            checks++;
            if (dec_ready !== exp_ready) $display("FAIL rand_ready c%0d: got %b want %b", c, dec_ready, exp_ready);
            else passed++;
            checks++;
            if (rs_enable !== exp_rs_en) $display("FAIL rand_rs_en c%0d: got %b want %b", c, rs_enable, exp_rs_en);
            else passed++;
            checks++;
            if (queue_count !== QC_W'(exp_size))
                $display("FAIL rand_count c%0d: got %0d want %0d", c, queue_count, exp_size);
            else passed++;
            checks++;
            if (state_dbg !== exp_state) $display("FAIL rand_state c%0d: got %0d want %0d", c, state_dbg, exp_state);
            else passed++;
            checks++;
            if (dispatch_valid !== exp_valid)
                $display("FAIL rand_valid c%0d: got %b want %b", c, dispatch_valid, exp_valid);
            else passed++;
            checks++;
            if (inst_out !== exp_inst) $display("FAIL rand_inst c%0d: got %h want %h", c, inst_out, exp_inst);
            else passed++;
            model_commit();
        end
        drain();
    endtask

`ifdef DISPATCH_STATS_EN
    task automatic test_stats();
        int base_rs, base_rob, base_fl;
        drive(2'b11, RSZ, 8, 8, 1'b0);
        model_commit();
        base_rs  = st_rs;
        base_rob = st_rob;
        base_fl  = st_fl;
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, RSZ, 0, 8, 1'b0);
            model_commit();
        end
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (stall_rob_cycles !== 32'(base_rob + 3))
            $display("FAIL stats_rob: got %0d want %0d", stall_rob_cycles, base_rob + 3);
        else passed++;
        checks++;
        if (stall_rs_cycles !== 32'(base_rs) || stall_fl_cycles !== 32'(base_fl))
            $display("FAIL stats_other: rs=%0d fl=%0d want %0d %0d", stall_rs_cycles, stall_fl_cycles, base_rs, base_fl);
        else passed++;
        model_commit();
        drain();
    endtask

    task automatic test_stats_totals();
        drive(2'b00, RSZ, 8, 8, 1'b0);
        checks++;
        if (stall_rs_cycles !== 32'(st_rs) || stall_rob_cycles !== 32'(st_rob) || stall_fl_cycles !== 32'(st_fl))
            $display("FAIL stats_totals: got %0d %0d %0d want %0d %0d %0d",
                     stall_rs_cycles, stall_rob_cycles, stall_fl_cycles, st_rs, st_rob, st_fl);
        else passed++;
        model_commit();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_dispatch();
        test_credit_limit();
        test_fill_and_wrap();
        test_sparse_lane();
        test_flush();
`ifdef DISPATCH_STATS_EN
        test_stats();
`endif
        test_random();
`ifdef DISPATCH_STATS_EN
        test_stats_totals();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
